// File: rtl/riscv_parcel_aligner.sv
// Parcel aligner: reassembles 16-bit parcels into RVC/32-bit instructions for decode.
// Optional RVC support is enabled by defining RISCV_PARCEL_ALIGNER_RVC_EN.
module riscv_parcel_aligner #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] PC_INIT     = 'h200,
  parameter int unsigned     PARCEL_SIZE = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] flush_pc_i,
  input  logic [31:0]     parcel_q_i,
  input  logic            parcel_misaligned_i,
  input  logic            parcel_page_fault_i,
  input  logic            parcel_error_i,
  input  logic            queue_empty_i,
  input  logic            queue_single_i,
  output logic [1:0]      parcel_rd_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic            instr_rvc_o,
  output logic            instr_misaligned_o,
  output logic            instr_page_fault_o,
  output logic            instr_error_o,
  output logic            instr_illegal_o
);

  localparam int unsigned PW = PARCEL_SIZE;

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_cnt_q, pc_cnt_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            valid_q, valid_d;
  logic            rvc_q, rvc_d;
  logic            mis_q, mis_d;
  logic            pf_q, pf_d;
  logic            err_q, err_d;
  logic            illegal_q, illegal_d;

  logic            fault;
  logic            is_len32;
  logic            is_illegal;
  logic            avail;
  logic            load;
  logic [1:0]      n_parcels;
  logic            unused_flush_lsb;

  assign unused_flush_lsb = flush_pc_i[0];
  assign fault = parcel_misaligned_i | parcel_page_fault_i | parcel_error_i;

`ifdef RISCV_PARCEL_ALIGNER_RVC_EN
  assign is_len32   = (parcel_q_i[1:0] == 2'b11);
  assign is_illegal = 1'b0;
`else
  // Without RVC every instruction is two parcels; a 16-bit encoding is flagged illegal.
  assign is_len32   = 1'b1;
  assign is_illegal = (parcel_q_i[1:0] != 2'b11);
`endif

  assign avail = !queue_empty_i && (!is_len32 || !queue_single_i);
  assign load  = (state_q == StRun) && avail && (!valid_q || instr_ready_i) && !flush_i &&
                 !rst_i;

  // A faulting head parcel is consumed alone regardless of its length encoding.
  assign n_parcels   = (fault || !is_len32) ? 2'd1 : 2'd2;
  assign parcel_rd_o = load ? n_parcels : 2'd0;

  always_comb begin
    state_d   = state_q;
    pc_cnt_d  = pc_cnt_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    rvc_d     = rvc_q;
    mis_d     = mis_q;
    pf_d      = pf_q;
    err_d     = err_q;
    illegal_d = illegal_q;

    if (load) begin
      valid_d   = 1'b1;
      pc_d      = pc_cnt_q;
      pc_cnt_d  = pc_cnt_q + ((n_parcels == 2'd1) ? XLEN'(2) : XLEN'(4));
      instr_d   = (n_parcels == 2'd1) ? {{(32 - PW){1'b0}}, parcel_q_i[PW-1:0]} : parcel_q_i;
      rvc_d     = !fault && !is_len32;
      mis_d     = parcel_misaligned_i;
      pf_d      = parcel_page_fault_i;
      err_d     = parcel_error_i;
      illegal_d = !fault && is_illegal;
      if (fault || is_illegal) begin
        state_d = StHalt;
      end
    end else if (instr_ready_i) begin
      valid_d = 1'b0;
    end

    if (flush_i) begin
      valid_d  = 1'b0;
      pc_cnt_d = {flush_pc_i[XLEN-1:1], 1'b0};
      state_d  = StRun;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StRun;
      pc_cnt_q  <= PC_INIT;
      pc_q      <= PC_INIT;
      instr_q   <= 32'h0000_0013;
      valid_q   <= 1'b0;
      rvc_q     <= 1'b0;
      mis_q     <= 1'b0;
      pf_q      <= 1'b0;
      err_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_cnt_q  <= pc_cnt_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      rvc_q     <= rvc_d;
      mis_q     <= mis_d;
      pf_q      <= pf_d;
      err_q     <= err_d;
      illegal_q <= illegal_d;
    end
  end

  assign instr_o            = instr_q;
  assign pc_o               = pc_q;
  assign instr_valid_o      = valid_q;
  assign instr_rvc_o        = rvc_q;
  assign instr_misaligned_o = mis_q;
  assign instr_page_fault_o = pf_q;
  assign instr_error_o      = err_q;
  assign instr_illegal_o    = illegal_q;

endmodule

// File: tb/tb_riscv_parcel_aligner.sv
// Randomized bench: a generated instruction stream is split into parcels and the
// decoded outputs are scored against the stream's own instruction/PC list.
module tb_riscv_parcel_aligner;

  localparam int unsigned XLEN = 32;
`ifdef RISCV_PARCEL_ALIGNER_RVC_EN
  localparam bit RvcEn = 1'b1;
`else
  localparam bit RvcEn = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [XLEN-1:0] flush_pc;
  logic [31:0]     parcel_q;
  logic            p_mis, p_pf, p_err;
  logic            q_empty, q_single;
  logic [1:0]      parcel_rd;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic            valid, ready;
  logic            rvc, mis, pf, err, ill;

  always #5 clk = ~clk;

  riscv_parcel_aligner #(.XLEN(XLEN), .PC_INIT('h200), .PARCEL_SIZE(16)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .flush_i            (flush),
    .flush_pc_i         (flush_pc),
    .parcel_q_i         (parcel_q),
    .parcel_misaligned_i(p_mis),
    .parcel_page_fault_i(p_pf),
    .parcel_error_i     (p_err),
    .queue_empty_i      (q_empty),
    .queue_single_i     (q_single),
    .parcel_rd_o        (parcel_rd),
    .instr_o            (instr),
    .pc_o               (pc),
    .instr_valid_o      (valid),
    .instr_ready_i      (ready),
    .instr_rvc_o        (rvc),
    .instr_misaligned_o (mis),
    .instr_page_fault_o (pf),
    .instr_error_o      (err),
    .instr_illegal_o    (ill)
  );

  typedef struct {
    logic [15:0] d;
    logic [2:0]  st;  // {error, page_fault, misaligned}
  } parcel_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        rvc;
    logic [2:0]  st;
    logic        ill;
    int          need;     // parcels that must be visible before it can load
    int          consume;  // parcels it removes from the queue
    bit          halt;
  } exp_t;

  parcel_t     pq[$];
  exp_t        eq[$];
  exp_t        cur;
  bit          exp_valid;
  bit          halted;
  bit          gen_halted;
  logic [31:0] gen_pc;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void push_parcel(logic [15:0] d, logic [2:0] st);
    parcel_t p;
    p.d  = d;
    p.st = st;
    pq.push_back(p);
  endfunction

  // Append one instruction to the stream with its expected decode result.
  task automatic gen_instr();
    exp_t        e;
    logic [31:0] w;
    int          kind;
    w         = $urandom;
    kind      = $urandom_range(0, 15);
    e.pc      = gen_pc;
    e.rvc     = 1'b0;
    e.st      = 3'b000;
    e.ill     = 1'b0;
    e.halt    = 1'b0;
    if (kind == 0) begin
      e.st = 3'($urandom_range(1, 7));
      push_parcel(w[15:0], e.st);
      push_parcel(w[31:16], 3'b000);
      e.instr   = {16'h0, w[15:0]};
      e.consume = 1;
      e.need    = (RvcEn && w[1:0] != 2'b11) ? 1 : 2;
      e.halt    = 1'b1;
      gen_pc    = gen_pc + 2;
    end else if (RvcEn && kind <= 7) begin
      w[1:0] = 2'($urandom_range(0, 2));
      push_parcel(w[15:0], 3'b000);
      e.instr   = {16'h0, w[15:0]};
      e.rvc     = 1'b1;
      e.consume = 1;
      e.need    = 1;
      gen_pc    = gen_pc + 2;
    end else begin
      if (!RvcEn && kind == 1) begin
        w[1:0] = 2'($urandom_range(0, 2));
        e.ill  = 1'b1;
        e.halt = 1'b1;
      end else begin
        w[1:0] = 2'b11;
      end
      push_parcel(w[15:0], 3'b000);
      push_parcel(w[31:16], 3'b000);
      e.instr   = w;
      e.consume = 2;
      e.need    = 2;
      gen_pc    = gen_pc + 4;
    end
    if (e.halt) gen_halted = 1'b1;
    eq.push_back(e);
  endtask

  task automatic run_cycle();
    int          vis;
    int          exp_rd;
    bit          do_flush;
    logic [31:0] fpc;
    while (!gen_halted && pq.size() < 8) gen_instr();

    vis = pq.size();
    if ($urandom_range(0, 3) == 0 && vis > 1) vis = $urandom_range(0, 1);
    q_empty  = (vis == 0);
    q_single = (vis == 0) ? 1'($urandom) : (vis == 1);
    parcel_q[15:0]  = (vis >= 1) ? pq[0].d : 16'($urandom);
    parcel_q[31:16] = (vis >= 2) ? pq[1].d : 16'($urandom);
    {p_err, p_pf, p_mis} = (vis >= 1) ? pq[0].st : 3'b000;
    ready = ($urandom_range(0, 3) != 0);

    do_flush = (halted && !exp_valid && $urandom_range(0, 2) == 0) ||
               ($urandom_range(0, 299) == 0);
    case ($urandom_range(0, 3))
      0:       fpc = 32'hFFFF_FFFD;
      1:       fpc = 32'h0000_1001;
      default: fpc = $urandom;
    endcase
    flush    = do_flush;
    flush_pc = fpc;

    exp_rd = 0;
    if (!do_flush && !halted && (!exp_valid || ready) && eq.size() > 0 && vis >= eq[0].need)
      exp_rd = eq[0].consume;

    @(negedge clk);
    check_eq("parcel_rd", 32'(parcel_rd), 32'(exp_rd));
    check_eq("valid", 32'(valid), 32'(exp_valid));
    if (exp_valid) begin
      check_eq("instr", instr, cur.instr);
      check_eq("pc", pc, cur.pc);
      check_eq("rvc", 32'(rvc), 32'(cur.rvc));
      check_eq("status", 32'({err, pf, mis}), 32'(cur.st));
      check_eq("illegal", 32'(ill), 32'(cur.ill));
    end

    @(posedge clk);
    if (do_flush) begin
      exp_valid  = 1'b0;
      halted     = 1'b0;
      gen_halted = 1'b0;
      pq.delete();
      eq.delete();
      gen_pc = {fpc[31:1], 1'b0};
    end else if (exp_rd != 0) begin
      for (int i = 0; i < exp_rd; i++) void'(pq.pop_front());
      cur       = eq.pop_front();
      exp_valid = 1'b1;
      halted    = cur.halt;
    end else if (ready) begin
      exp_valid = 1'b0;
    end
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    flush    = 1'b1;
    flush_pc = 32'h0000_4000;
    parcel_q = 32'h0010_0093;
    {p_err, p_pf, p_mis} = 3'b000;
    q_empty  = 1'b0;
    q_single = 1'b0;
    ready    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("reset parcel_rd", 32'(parcel_rd), 32'd0);
    check_eq("reset valid", 32'(valid), 32'd0);
    check_eq("reset instr", instr, 32'h0000_0013);
    check_eq("reset pc", pc, 32'h0000_0200);
    check_eq("reset rvc", 32'(rvc), 32'd0);
    check_eq("reset status", 32'({err, pf, mis}), 32'd0);
    check_eq("reset illegal", 32'(ill), 32'd0);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    flush      = 1'b0;
    exp_valid  = 1'b0;
    halted     = 1'b0;
    gen_halted = 1'b0;
    gen_pc     = 32'h0000_0200;
    for (int c = 0; c < 5000; c++) run_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
